// File: rtl/ex_mem_pkg.sv
// Shared datapath widths, constants and stall decode for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int REG_BUS_W        = 32;
  localparam int REG_ADDR_BUS_W   = 5;
  localparam int DOUBLE_REG_BUS_W = 64;
  localparam int STALL_W          = 6;

  localparam logic [REG_BUS_W-1:0]        ZERO_WORD   = '0;
  localparam logic [DOUBLE_REG_BUS_W-1:0] ZERO_DWORD  = '0;
  localparam logic [REG_ADDR_BUS_W-1:0]   NOP_REG     = '0;
  localparam logic                        WRITE_EN    = 1'b1;
  localparam logic                        WRITE_DIS   = 1'b0;
  localparam logic                        STOP        = 1'b1;
  localparam logic                        NO_STOP     = 1'b0;

  localparam int EX_STAGE  = 3;
  localparam int MEM_STAGE = 4;

  typedef enum logic [1:0] {
    ACT_PASS,
    ACT_BUBBLE,
    ACT_HOLD
  } stage_act_e;

  // EX stalled with MEM running leaves a hole that must be filled with a bubble;
  // MEM stalled with EX running cannot happen legally and is treated as a pass.
  function automatic stage_act_e stage_act(input logic ex_stop, input logic mem_stop);
    if (ex_stop == NO_STOP)       return ACT_PASS;
    else if (mem_stop == NO_STOP) return ACT_BUBBLE;
    else                          return ACT_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall/bubble handling and MADD/MSUB accumulate feedback.
// Optional synchronous flush port is compiled in when EX_MEM_FLUSH_EN is defined.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
`ifdef EX_MEM_FLUSH_EN
  input  logic        flush,
`endif
  input  logic [4:0]  ex_rw,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [63:0] hilo_temp_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_rw,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o
);

  stage_act_e act;
  logic       clear;
  logic       unused_stall;

  assign act          = stage_act(stall[EX_STAGE], stall[MEM_STAGE]);
  assign unused_stall = ^{stall[5], stall[2:0]};

`ifdef EX_MEM_FLUSH_EN
  assign clear = flush;
`else
  assign clear = 1'b0;
`endif

  // NOTE: pipeline state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, whatever order the statements run in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      mem_rw      <= NOP_REG;
      mem_wreg    <= WRITE_DIS;
      mem_wdata   <= ZERO_WORD;
      mem_whilo   <= WRITE_DIS;
      mem_hi      <= ZERO_WORD;
      mem_lo      <= ZERO_WORD;
      hilo_temp_o <= ZERO_DWORD;
      cnt_o       <= 2'b00;
    end else begin
      unique case (act)
        ACT_PASS: begin
          mem_rw      <= ex_rw;
          mem_wreg    <= ex_wreg;
          mem_wdata   <= ex_wdata;
          mem_whilo   <= ex_whilo;
          mem_hi      <= ex_hi;
          mem_lo      <= ex_lo;
          hilo_temp_o <= ZERO_DWORD;
          cnt_o       <= 2'b00;
        end
        ACT_BUBBLE: begin
          mem_rw      <= NOP_REG;
          mem_wreg    <= WRITE_DIS;
          mem_wdata   <= ZERO_WORD;
          mem_whilo   <= WRITE_DIS;
          mem_hi      <= ZERO_WORD;
          mem_lo      <= ZERO_WORD;
          hilo_temp_o <= hilo_temp_i;
          cnt_o       <= cnt_i;
        end
        default: begin
          // Hold: mem_* keep their value, EX still parks its partial product here.
          hilo_temp_o <= hilo_temp_i;
          cnt_o       <= cnt_i;
        end
      endcase
    end
  end

endmodule
